// File: rtl/ps2_scancode_fifo.sv
// ---------------------------------------------------------------------------
// ps2_scancode_fifo
//
// Drains raw scancode bytes from a PS/2 receiver using its ready/nextdata
// handshake. Folds the E0 (extended) and F0 (break) prefixes into a single
// key event. Optionally drops typematic repeats. Buffers the decoded events
// in a DEPTH-entry FIFO that a consumer reads over valid/ready.
//
// Ports
//   clk               system clock
//   rst               asynchronous active-low reset
//   ps2read_data      byte at the head of the receiver
//   ps2read_ready     receiver holds at least one byte
//   ps2read_nextdata  one-cycle pulse that pops the receiver head
//   flush             synchronous clear of FIFO, prefix flags and repeat tracker
//   evt_data          head event {break, extended, code[7:0]}
//   evt_valid         FIFO non-empty
//   evt_ready         consumer takes the head event when evt_valid=1
//   evt_count         number of stored events (0..DEPTH)
//   prefix_pending    an E0/F0 prefix is latched and awaits its code byte
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a byte that can be accepted; classify on accept
//   ACK    | ps2read_nextdata high for this single cycle
//   WAIT   | settle cycle so the receiver head pointer advances
// ---------------------------------------------------------------------------
module ps2_scancode_fifo #(
  parameter int DEPTH         = 8,
  parameter int FILTER_REPEAT = 1,
  parameter int AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ps2read_data,
  input  logic          ps2read_ready,
  output logic          ps2read_nextdata,
  input  logic          flush,
  output logic [9:0]    evt_data,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [AW:0]   evt_count,
  output logic          prefix_pending
);

  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
  localparam bit          FILTER_EN = (FILTER_REPEAT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  // Prefix flags
  logic ext_q;
  logic brk_q;

  // Repeat tracker: {ext, code} of the last written make event
  logic       trk_valid;
  logic [8:0] trk_key;

  // FIFO storage and pointers
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Byte classification
  logic       is_ext_pfx;
  logic       is_brk_pfx;
  logic       is_prefix;
  logic       is_err;
  logic       is_code;
  logic [8:0] cur_key;
  logic       repeat_hit;
  logic       drop;
  logic       fifo_full;
  logic       accept;
  logic       push;
  logic       pop;

  always_comb begin
    is_ext_pfx = (ps2read_data == 8'hE0);
    is_brk_pfx = (ps2read_data == 8'hF0);
    is_prefix  = is_ext_pfx | is_brk_pfx;
    is_err     = (ps2read_data == 8'h00) | (ps2read_data == 8'hFF);
    is_code    = ~is_prefix & ~is_err;
  end

  assign cur_key = {ext_q, ps2read_data};

  // Only a make can be a repeat; breaks are always written.
  assign repeat_hit = FILTER_EN & trk_valid & ~brk_q & (trk_key == cur_key);

  // Bytes that are consumed without producing an event never need FIFO space.
  assign drop      = is_err | (is_code & repeat_hit);
  assign fifo_full = (evt_count == FULL_CNT);

  // Fullness is judged on the count before this cycle's pop, so a full FIFO
  // stalls for one cycle even when the consumer is reading.
  assign accept = (state == S_IDLE) & ps2read_ready & ~flush &
                  (is_prefix | drop | ~fifo_full);

  assign push = accept & is_code & ~repeat_hit;
  assign pop  = evt_valid & evt_ready;

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A flush never cuts the handshake short: an ACK in progress still issues
  // its pulse and the settle cycle, after which the FSM is back in IDLE.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_ACK;
        end
      end
      S_ACK: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign ps2read_nextdata = (state == S_ACK);

  // -------------------------------------------------------------------------
  // Prefix flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (flush) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (accept) begin
      if (is_ext_pfx) begin
        ext_q <= 1'b1;
      end else if (is_brk_pfx) begin
        brk_q <= 1'b1;
      end else if (is_code) begin
        // Filtered repeats still terminate their prefix sequence.
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign prefix_pending = ext_q | brk_q;

  // -------------------------------------------------------------------------
  // Repeat tracker
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_valid <= 1'b0;
      trk_key   <= 9'd0;
    end else if (flush) begin
      trk_valid <= 1'b0;
      trk_key   <= 9'd0;
    end else if (push) begin
      if (!brk_q) begin
        trk_valid <= 1'b1;
        trk_key   <= cur_key;
      end else if (trk_valid && (trk_key == cur_key)) begin
        // Key released: the next make of it is a fresh press.
        trk_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {brk_q, ext_q, ps2read_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   evt_count <= evt_count + (AW + 1)'(1);
        2'b01:   evt_count <= evt_count - (AW + 1)'(1);
        default: evt_count <= evt_count;
      endcase
    end
  end

  assign evt_valid = (evt_count != '0);

  // Empty FIFO presents zero rather than stale or uninitialised storage.
  assign evt_data = evt_valid ? mem[rd_ptr] : 10'd0;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
module tb_ps2_scancode_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    ps2read_data  = 8'h00;
  logic          ps2read_ready = 1'b0;
  logic          ps2read_nextdata;
  logic          flush;
  logic [9:0]    evt_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [AW:0]   evt_count;
  logic          prefix_pending;

  ps2_scancode_fifo #(
    .DEPTH(DEPTH),
    .FILTER_REPEAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2read_data(ps2read_data),
    .ps2read_ready(ps2read_ready),
    .ps2read_nextdata(ps2read_nextdata),
    .flush(flush),
    .evt_data(evt_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_count(evt_count),
    .prefix_pending(prefix_pending)
  );

  always #5 clk = ~clk;

  // Receiver model: bytes[] is appended by the stimulus, rd_idx is the head.
  logic [7:0] bytes [$];
  int         rd_idx = 0;
  logic [9:0] got [$];
  int         pulse_cyc [$];
  int         cyc = 0;

  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps2read_nextdata) begin
      pulse_cyc.push_back(cyc);
      if (rd_idx < bytes.size()) rd_idx = rd_idx + 1;
    end
    if (evt_valid && evt_ready) got.push_back(evt_data);
    if (rd_idx < bytes.size()) begin
      ps2read_ready = 1'b1;
      ps2read_data  = bytes[rd_idx];
    end else begin
      ps2read_ready = 1'b0;
      ps2read_data  = 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int gb;
  int pb;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    evt_ready = 1'b0;
    #1 rst = 1'b0;
    tick(2);
    check("rst_nextdata", 32'(ps2read_nextdata), 32'd0);
    check("rst_valid",    32'(evt_valid),        32'd0);
    check("rst_count",    32'(evt_count),        32'd0);
    check("rst_data",     32'(evt_data),         32'd0);
    check("rst_prefix",   32'(prefix_pending),   32'd0);
    rst = 1'b1;
    tick(2);

    // 1C, F0 1C: make then break, pulses 3 cycles apart
    evt_ready = 1'b1;
    gb = got.size();
    pb = pulse_cyc.size();
    bytes.push_back(8'h1C);
    bytes.push_back(8'hF0);
    bytes.push_back(8'h1C);
    tick(14);
    check("t1_nevt",   32'(got.size() - gb),       32'd2);
    check("t1_evt0",   32'(got[gb]),               32'h01C);
    check("t1_evt1",   32'(got[gb + 1]),           32'h21C);
    check("t1_pulses", 32'(pulse_cyc.size() - pb), 32'd3);
    check("t1_gap0",   32'(pulse_cyc[pb + 1] - pulse_cyc[pb]),     32'd3);
    check("t1_gap1",   32'(pulse_cyc[pb + 2] - pulse_cyc[pb + 1]), 32'd3);

    // E0 F0 75: single extended break event
    gb = got.size();
    bytes.push_back(8'hE0);
    tick(6);
    check("t2_pp_e0",  32'(prefix_pending), 32'd1);
    check("t2_nv_e0",  32'(got.size() - gb), 32'd0);
    bytes.push_back(8'hF0);
    tick(6);
    check("t2_pp_f0",  32'(prefix_pending), 32'd1);
    bytes.push_back(8'h75);
    tick(6);
    check("t2_pp_75",  32'(prefix_pending), 32'd0);
    check("t2_nevt",   32'(got.size() - gb), 32'd1);
    check("t2_evt",    32'(got[gb]),         32'h375);

    // Repeat filter: 1C 1C 1C F0 1C 1C
    gb = got.size();
    pb = pulse_cyc.size();
    bytes.push_back(8'h1C);
    bytes.push_back(8'h1C);
    bytes.push_back(8'h1C);
    bytes.push_back(8'hF0);
    bytes.push_back(8'h1C);
    bytes.push_back(8'h1C);
    tick(26);
    check("t3_nevt",   32'(got.size() - gb),       32'd3);
    check("t3_evt0",   32'(got[gb]),               32'h01C);
    check("t3_evt1",   32'(got[gb + 1]),           32'h21C);
    check("t3_evt2",   32'(got[gb + 2]),           32'h01C);
    check("t3_pulses", 32'(pulse_cyc.size() - pb), 32'd6);

    // Back-pressure on a full FIFO, then drain across pointer wrap
    evt_ready = 1'b0;
    gb = got.size();
    pb = pulse_cyc.size();
    bytes.push_back(8'h11);
    bytes.push_back(8'h22);
    bytes.push_back(8'h33);
    bytes.push_back(8'h44);
    bytes.push_back(8'h55);
    tick(24);
    check("t4_count_full", 32'(evt_count),              32'd4);
    check("t4_pulses4",    32'(pulse_cyc.size() - pb),  32'd4);
    check("t4_head",       32'(evt_data),               32'h011);
    check("t4_nextdata",   32'(ps2read_nextdata),       32'd0);
    tick(6);
    check("t4_still4",     32'(pulse_cyc.size() - pb),  32'd4);
    evt_ready = 1'b1;
    tick(20);
    check("t4_pulses5",    32'(pulse_cyc.size() - pb),  32'd5);
    check("t4_nevt",       32'(got.size() - gb),        32'd5);
    check("t4_evt0",       32'(got[gb]),                32'h011);
    check("t4_evt1",       32'(got[gb + 1]),            32'h022);
    check("t4_evt2",       32'(got[gb + 2]),            32'h033);
    check("t4_evt3",       32'(got[gb + 3]),            32'h044);
    check("t4_evt4",       32'(got[gb + 4]),            32'h055);
    check("t4_count0",     32'(evt_count),              32'd0);

    // Receiver error codes are discarded
    gb = got.size();
    pb = pulse_cyc.size();
    bytes.push_back(8'h00);
    bytes.push_back(8'hFF);
    bytes.push_back(8'h2A);
    tick(14);
    check("t5_nevt",   32'(got.size() - gb),       32'd1);
    check("t5_evt",    32'(got[gb]),               32'h02A);
    check("t5_pulses", 32'(pulse_cyc.size() - pb), 32'd3);

    // Reset between E0 and the code byte; tracker holds 1C beforehand
    gb = got.size();
    bytes.push_back(8'h1C);
    bytes.push_back(8'hE0);
    tick(12);
    check("t6_pp_pre", 32'(prefix_pending), 32'd1);
    rst = 1'b0;
    #2;
    check("t6_rst_nextdata", 32'(ps2read_nextdata), 32'd0);
    check("t6_rst_valid",    32'(evt_valid),        32'd0);
    check("t6_rst_count",    32'(evt_count),        32'd0);
    check("t6_rst_data",     32'(evt_data),         32'd0);
    check("t6_rst_prefix",   32'(prefix_pending),   32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    bytes.push_back(8'h1C);
    tick(8);
    check("t6_nevt",   32'(got.size() - gb), 32'd2);
    check("t6_evt0",   32'(got[gb]),         32'h01C);
    check("t6_evt1",   32'(got[gb + 1]),     32'h01C);
    check("t6_pp",     32'(prefix_pending),  32'd0);

    // Same with flush; F0 1C 1C leaves the tracker holding 1C first
    gb = got.size();
    bytes.push_back(8'hF0);
    bytes.push_back(8'h1C);
    bytes.push_back(8'h1C);
    bytes.push_back(8'hE0);
    tick(16);
    check("t7_pp_pre", 32'(prefix_pending), 32'd1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t7_pp_flush",    32'(prefix_pending), 32'd0);
    check("t7_count_flush", 32'(evt_count),      32'd0);
    bytes.push_back(8'h1C);
    tick(8);
    check("t7_nevt",   32'(got.size() - gb), 32'd3);
    check("t7_evt0",   32'(got[gb]),         32'h21C);
    check("t7_evt1",   32'(got[gb + 1]),     32'h01C);
    check("t7_evt2",   32'(got[gb + 2]),     32'h01C);
    check("t7_drained", 32'(rd_idx),         32'(bytes.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
Parametrised successor to the single-byte PS/2 read stage. It drains raw scancode bytes from the PS/2 receiver using the ready/nextdata handshake. It folds the 0xE0 (extended) and 0xF0 (break) prefixes into one key event and can optionally suppress typematic repeats. Decoded events are buffered in a DEPTH-entry FIFO and handed to the consumer (CPU MMIO or a display driver) over a valid/ready interface.

Parameters:
DEPTH, 8, number of FIFO event entries; must be a power of two and at least 2.
FILTER_REPEAT, 1, 1 = drop a make event identical to the last accepted make while that key is still held.
AW, $clog2(DEPTH), derived address width; must not be overridden.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
ps2read_data  in  8  byte at the head of the PS/2 receiver.
ps2read_ready  in  1  receiver holds at least one byte.
ps2read_nextdata  out  1  one-cycle pulse that pops one byte from the receiver.
flush  in  1  synchronous clear of the FIFO, prefix flags and repeat tracker.
evt_data  out  10  head event: [9]=break, [8]=extended, [7:0]=code.
evt_valid  out  1  FIFO non-empty.
evt_ready  in  1  consumer accepts the head event when evt_valid=1.
evt_count  out  AW+1  number of events currently stored (0..DEPTH).
prefix_pending  out  1  an E0 or F0 prefix has been latched and no code byte has followed yet.

Behaviour:
- Reset (rst=0, asynchronous):
  - ps2read_nextdata=0, evt_valid=0, evt_count=0, evt_data=0, prefix_pending=0.
  - ext and brk flags cleared, repeat tracker invalid, FSM in IDLE.
- FSM states and transitions:
  - IDLE -> ACK when ps2read_ready=1 and the byte is accepted. A byte is accepted if it is a prefix, a dropped byte, or (evt_count < DEPTH).
    - Acceptance uses evt_count before this cycle's pop, so a full FIFO stalls even when evt_ready=1 in the same cycle.
    - At the accepting edge the byte is classified, flags are updated and the FIFO write is performed.
  - ACK: ps2read_nextdata=1 for exactly one cycle; then -> WAIT.
  - WAIT: one idle cycle so the receiver head pointer settles; then -> IDLE.
  - Peak throughput is one byte per 3 cycles.
  - If the FIFO is full and the head byte is a code, stay in IDLE and do not pulse nextdata; the byte stays in the receiver (back-pressure, never dropped).
- Byte classification:
  - 0xE0: set ext; no event.
  - 0xF0: set brk; no event.
  - Prefix order is irrelevant (E0 F0 and F0 E0 are both legal). A repeated prefix is idempotent.
  - 0x00 and 0xFF (receiver error codes): consumed and discarded; flags unchanged.
  - Any other byte, including 0xE1 and 0xAA: candidate event {brk, ext, byte}. ext and brk clear at the same edge.
- Repeat filter (FILTER_REPEAT=1):
  - Tracker holds {ext, code} of the last written make event, plus a valid bit.
  - A make that matches a valid tracker is consumed but not written.
  - A written make loads the tracker.
  - A break that matches the tracker invalidates it. A break is always written.
  - With FILTER_REPEAT=0 the tracker has no effect.
- prefix_pending = ext | brk.
- FIFO:
  - evt_data = mem[rd_ptr], combinational from the registered pointer.
  - A pop occurs when evt_valid & evt_ready; a pop on empty is ignored.
  - Simultaneous push and pop leaves evt_count unchanged.
  - Pointers are AW bits wide and wrap modulo DEPTH.
  - First-event latency: a code byte accepted at edge N gives evt_valid=1 after edge N.
- flush=1 (synchronous, lower priority than rst):
  - Pointers, count, flags and tracker are cleared.
  - The FSM returns to IDLE; an ACK in progress still completes its nextdata pulse first, so the receiver stays consistent.
  - Any write from that same edge is discarded.
- rst asserted mid-sequence (e.g. between E0 and the code byte): prefix state is lost and the next code byte is decoded without prefixes.

Test Plan:
- Bytes 1C, F0 1C (ready held, evt_ready=1) -> events 0x01C then 0x21C; exactly 3 nextdata pulses, each 3 cycles apart.
- Bytes E0 F0 75 -> a single event 0x375; prefix_pending=1 after E0 and after F0, 0 after 75.
- FILTER_REPEAT=1, bytes 1C 1C 1C F0 1C 1C -> events 0x01C, 0x21C, 0x01C; all 6 bytes popped.
- DEPTH=4, evt_ready=0, five code bytes -> evt_count=4; the fifth byte is never popped (nextdata stays 0). Raise evt_ready -> the fifth is accepted, and order is preserved across pointer wrap.
- Bytes 00, FF, 2A -> one event 0x02A; 3 pops.
- E0 followed by rst=0 pulse, then 1C -> outputs at reset values during reset; event 0x01C with no ext bit. Repeat the test with flush instead of rst -> same result.
